// File: rtl/ram_dump_reader.sv
// ram_dump_reader
//   Walks the CPU RAM from FIRST_ADDR to LAST_ADDR (wrapping modulo 2^ADDR_W).
//   Each word is returned with its address over a valid/ready stream.
//   A modulo-2^DATA_W checksum of the accepted words is kept alongside.
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_start      dump request, taken when idle (or leaving DONE) and not in load mode
//   i_load_mode  loader owns the RAM; blocks start, aborts a running dump
//   o_dump_rd    RAM read strobe (high in READ)
//   o_dump_addr  RAM read address
//   i_ram_data   RAM read data, one clock after o_dump_rd
//   o_out_valid  o_out_data/o_out_addr hold a word
//   i_out_ready  consumer accepts the word
//   o_out_data   dumped word
//   o_out_addr   address of o_out_data
//   o_busy       high in every state except IDLE
//   o_done       one-cycle pulse after the last word is accepted
//   o_checksum   sum of accepted words, valid from the done pulse onward
module ram_dump_reader #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIRST_ADDR = 0,
    parameter int unsigned LAST_ADDR  = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_load_mode,
    output logic              o_dump_rd,
    output logic [ADDR_W-1:0] o_dump_addr,
    input  logic [DATA_W-1:0] i_ram_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_checksum
);

    localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(LAST_ADDR);

    typedef enum logic [2:0] {StIdle, StRead, StCapture, StHold, StDone} state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_sum;
    logic [DATA_W-1:0] r_checksum;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_valid;

    state_e            w_state_d;
    logic [ADDR_W-1:0] w_addr_d;
    logic [DATA_W-1:0] w_sum_d;
    logic [DATA_W-1:0] w_checksum_d;
    logic [DATA_W-1:0] w_out_data_d;
    logic [ADDR_W-1:0] w_out_addr_d;
    logic              w_out_valid_d;
    logic [DATA_W-1:0] w_sum_acc;

    assign w_sum_acc = r_sum + r_out_data;

    always_comb begin
        w_state_d     = r_state;
        w_addr_d      = r_addr;
        w_sum_d       = r_sum;
        w_checksum_d  = r_checksum;
        w_out_data_d  = r_out_data;
        w_out_addr_d  = r_out_addr;
        w_out_valid_d = r_out_valid;

        case (r_state)
            StIdle: begin
                if (i_start && !i_load_mode) begin
                    w_addr_d  = FirstAddr;
                    w_sum_d   = '0;
                    w_state_d = StRead;
                end
            end
            StRead: begin
                w_state_d = StCapture;
            end
            StCapture: begin
                w_out_data_d  = i_ram_data;
                w_out_addr_d  = r_addr;
                w_out_valid_d = 1'b1;
                w_state_d     = StHold;
            end
            StHold: begin
                if (i_out_ready) begin
                    w_sum_d       = w_sum_acc;
                    w_out_valid_d = 1'b0;
                    if (r_addr == LastAddr) begin
                        // Publish with the final sum so checksum is valid during done.
                        w_checksum_d = w_sum_acc;
                        w_state_d    = StDone;
                    end else begin
                        w_addr_d  = r_addr + ADDR_W'(1);
                        w_state_d = StRead;
                    end
                end
            end
            StDone: begin
                // A new dump may be accepted on the edge that leaves DONE.
                if (i_start && !i_load_mode) begin
                    w_addr_d  = FirstAddr;
                    w_sum_d   = '0;
                    w_state_d = StRead;
                end else begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Loader takes the RAM: drop everything, keep the old checksum.
        if (i_load_mode && (r_state != StIdle)) begin
            w_state_d     = StIdle;
            w_out_valid_d = 1'b0;
            w_checksum_d  = r_checksum;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_sum       <= '0;
            r_checksum  <= '0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_addr      <= w_addr_d;
            r_sum       <= w_sum_d;
            r_checksum  <= w_checksum_d;
            r_out_data  <= w_out_data_d;
            r_out_addr  <= w_out_addr_d;
            r_out_valid <= w_out_valid_d;
        end
    end

    assign o_dump_rd   = (r_state == StRead);
    assign o_dump_addr = r_addr;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_addr  = r_out_addr;
    assign o_busy      = (r_state != StIdle);
    assign o_done      = (r_state == StDone);
    assign o_checksum  = r_checksum;

endmodule

// File: tb/tb_ram_dump_reader.sv
// Directed bench for ram_dump_reader: full image dump, busy-start, backpressure,
// abort via load_mode, asynchronous reset mid-dump, and a wrapping address range.
module tb_ram_dump_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset     = 1'b0;
    logic       start_a   = 1'b0;
    logic       start_b   = 1'b0;
    logic       load_mode = 1'b0;
    logic       out_ready = 1'b1;

    logic       rd_a, rd_b, valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [3:0] addr_a, addr_b, oaddr_a, oaddr_b;
    logic [7:0] rdata_a = '0;
    logic [7:0] rdata_b = '0;
    logic [7:0] odata_a, odata_b, sum_a, sum_b;
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];

    int total = 0;
    int bad   = 0;

    // Registered RAM models.
    always @(posedge clk) begin
        if (rd_a) rdata_a <= mem_a[addr_a];
        if (rd_b) rdata_b <= mem_b[addr_b];
    end

    ram_dump_reader #(.ADDR_W(4), .DATA_W(8), .FIRST_ADDR(0), .LAST_ADDR(15)) u_dut_a (
        .i_clk(clk), .i_reset(reset), .i_start(start_a), .i_load_mode(load_mode),
        .o_dump_rd(rd_a), .o_dump_addr(addr_a), .i_ram_data(rdata_a),
        .o_out_valid(valid_a), .i_out_ready(out_ready), .o_out_data(odata_a),
        .o_out_addr(oaddr_a), .o_busy(busy_a), .o_done(done_a), .o_checksum(sum_a)
    );

    ram_dump_reader #(.ADDR_W(4), .DATA_W(8), .FIRST_ADDR(14), .LAST_ADDR(1)) u_dut_b (
        .i_clk(clk), .i_reset(reset), .i_start(start_b), .i_load_mode(load_mode),
        .o_dump_rd(rd_b), .o_dump_addr(addr_b), .i_ram_data(rdata_b),
        .o_out_valid(valid_b), .i_out_ready(out_ready), .o_out_data(odata_b),
        .o_out_addr(oaddr_b), .o_busy(busy_b), .o_done(done_b), .o_checksum(sum_b)
    );

    // Observation mux: sel=1 watches the wrap-range instance.
    logic       sel = 1'b0;
    logic       m_rd, m_valid, m_busy, m_done;
    logic [3:0] m_dump_addr, m_addr;
    logic [7:0] m_data, m_sum;
    assign m_rd        = sel ? rd_b    : rd_a;
    assign m_valid     = sel ? valid_b : valid_a;
    assign m_busy      = sel ? busy_b  : busy_a;
    assign m_done      = sel ? done_b  : done_a;
    assign m_dump_addr = sel ? addr_b  : addr_a;
    assign m_addr      = sel ? oaddr_b : oaddr_a;
    assign m_data      = sel ? odata_b : odata_a;
    assign m_sum       = sel ? sum_b   : sum_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one dump, checking order, data, timing (when not backpressured),
    // stability under backpressure, a single done pulse and the checksum.
    task automatic run_dump(input bit use_b, input bit bp, input int first, input int last,
                            input logic [7:0] exp_sum, input int pulse_word, input string tag);
        int         n_words, widx, done_cnt, done_c;
        bit         finished, holding;
        logic [7:0] h_data, ed;
        logic [3:0] h_addr, ea;
        n_words  = ((last - first + 16) % 16) + 1;
        widx     = 0;
        done_cnt = 0;
        done_c   = -1;
        finished = 1'b0;
        holding  = 1'b0;
        h_data   = '0;
        h_addr   = '0;
        sel      = use_b;
        @(negedge clk);
        out_ready = 1'b1;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        for (int c = 0; c < 400 && !finished; c++) begin
            if (c == 0) begin
                check({tag, "_rd"}, 32'(m_rd), 32'd1);
                check({tag, "_rdaddr"}, 32'(m_dump_addr), 32'(first));
            end
            if (c == 1) check({tag, "_valid_c1"}, 32'(m_valid), 32'd0);
            if (bp) out_ready = 1'($urandom_range(0, 1));
            if (pulse_word >= 0) begin
                start_a = m_valid && (32'(m_addr) == pulse_word);
            end
            if (m_valid) begin
                if (holding) begin
                    check({tag, "_stable_data"}, 32'(m_data), 32'(h_data));
                    check({tag, "_stable_addr"}, 32'(m_addr), 32'(h_addr));
                end
                if (out_ready) begin
                    ea = 4'((first + widx) % 16);
                    ed = use_b ? mem_b[ea] : mem_a[ea];
                    check({tag, "_addr"}, 32'(m_addr), 32'(ea));
                    check({tag, "_data"}, 32'(m_data), 32'(ed));
                    if (!bp) check({tag, "_accept_cycle"}, 32'(c), 32'(2 + 3 * widx));
                    widx++;
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    h_data  = m_data;
                    h_addr  = m_addr;
                end
            end
            if (m_done) begin
                done_cnt++;
                done_c = c;
            end
            if (c > 0 && !m_busy) finished = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_words"}, 32'(widx), 32'(n_words));
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        if (!bp) check({tag, "_done_cycle"}, 32'(done_c), 32'(3 * n_words));
        check({tag, "_checksum"}, 32'(m_sum), 32'(exp_sum));
        check({tag, "_busy_end"}, 32'(m_busy), 32'd0);
        start_a   = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h5A;
        end
        mem_a[0] = 8'h79; mem_a[1] = 8'h30; mem_a[2]  = 8'h7A; mem_a[3]  = 8'h10;
        mem_a[4] = 8'h40; mem_a[9] = 8'h07; mem_a[10] = 8'h0A;
        mem_b[14] = 8'hFF; mem_b[15] = 8'h02; mem_b[0] = 8'h79; mem_b[1] = 8'h30;

        // Reset state.
        #3 reset = 1'b1;
        #1;
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_rd", 32'(rd_a), 32'd0);
        check("rst_dump_addr", 32'(addr_a), 32'd0);
        check("rst_out_data", 32'(odata_a), 32'd0);
        check("rst_out_addr", 32'(oaddr_a), 32'd0);
        check("rst_checksum", 32'(sum_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Image dump; 0x79+0x30+0x7A+0x10+0x40+0x07+0x0A = 0x184.
        run_dump(1'b0, 1'b0, 0, 15, 8'h84, -1, "image");
        // start pulsed while word 3 is held must not disturb the dump.
        run_dump(1'b0, 1'b0, 0, 15, 8'h84, 3, "busy_start");
        run_dump(1'b0, 1'b1, 0, 15, 8'h84, -1, "bp");

        // Abort with word 5 in HOLD.
        sel = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        start_a   = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (valid_a && oaddr_a == 4'd5) break;
            out_ready = 1'b1;
            @(negedge clk);
        end
        check("abort_hold", {27'd0, valid_a, oaddr_a}, {27'd0, 1'b1, 4'd5});
        out_ready = 1'b0;
        load_mode = 1'b1;
        @(negedge clk);
        check("abort_valid", 32'(valid_a), 32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        check("abort_checksum", 32'(sum_a), 32'h84);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("loadmode_start_busy", 32'(busy_a), 32'd0);
        check("loadmode_start_rd", 32'(rd_a), 32'd0);
        @(negedge clk);
        check("loadmode_start_busy2", 32'(busy_a), 32'd0);
        load_mode = 1'b0;
        out_ready = 1'b1;

        // Asynchronous reset between edges while a word is held.
        @(negedge clk);
        out_ready = 1'b0;
        start_a   = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_pre_valid", 32'(valid_a), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_valid", 32'(valid_a), 32'd0);
        check("rst_mid_busy", 32'(busy_a), 32'd0);
        check("rst_mid_done", 32'(done_a), 32'd0);
        check("rst_mid_rd", 32'(rd_a), 32'd0);
        check("rst_mid_dump_addr", 32'(addr_a), 32'd0);
        check("rst_mid_out_data", 32'(odata_a), 32'd0);
        check("rst_mid_out_addr", 32'(oaddr_a), 32'd0);
        check("rst_mid_checksum", 32'(sum_a), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        run_dump(1'b0, 1'b0, 0, 15, 8'h84, -1, "after_rst");

        // Wrap range E,F,0,1: 0xFF+0x02+0x79+0x30 = 0x1AA.
        run_dump(1'b1, 1'b0, 14, 1, 8'hAA, -1, "wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
